turf_cmd_framer: RTL

Downstream consumer of the system clock block: frames 32-bit TURF→SURF command words onto the 500 Mbit/s command link. Runs on the 125 MHz sysclk and aligns each word to the 8-clock command period marked by toggles of the global sysclk phase signal. Emits one 4-bit nibble per clock to a 4:1 output serializer, so one word occupies exactly one period. Buffers queued commands in a small FIFO and inserts an idle word when none is available.

---
 rtl/turf_cmd_framer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/turf_cmd_framer.sv
// TURF->SURF command framer: 32-bit words as 8 nibbles per sysclk phase period.
// Small command FIFO in front; idle word fills periods without a command.
module turf_cmd_framer #(
  parameter logic [31:0] IDLE_WORD  = 32'hA55A_A55A,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        sysclk_phase_i,
  input  logic        enable_i,
  input  logic        err_clr_i,
  input  logic [31:0] cmd_tdata,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  output logic [3:0]  cmd_par_o,
  output logic        frame_start_o,
  output logic        aligned_o,
  output logic        align_err_o,
  output logic [15:0] cmd_count_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {UNALIGNED, ALIGNED} state_t;

  state_t          state, state_n;
  logic            phase_q;
  logic            toggle;
  logic [2:0]      nib_cnt, nib_n;
  logic [31:0]     sr, sr_n;
  logic [3:0]      par_n;
  logic            fs_n;
  logic            load, adv, err_evt;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   occ, occ_n;
  logic            push, pop;
  logic [31:0]     load_word;

  assign toggle    = sysclk_phase_i ^ phase_q;
  assign push      = cmd_tvalid & cmd_tready;
  assign pop       = load & enable_i & (occ != '0);
  assign load_word = pop ? mem[rd_ptr] : IDLE_WORD;
  assign aligned_o = (state == ALIGNED);

  // State register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= UNALIGNED;
    else       state <= state_n;
  end

  // Next state plus the load/advance/error decisions for this edge.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    err_evt = 1'b0;
    unique case (state)
      UNALIGNED: begin
        if (toggle) begin
          state_n = ALIGNED;
          load    = 1'b1;
        end
      end
      ALIGNED: begin
        if (toggle) begin
          load    = 1'b1;
          err_evt = (nib_cnt != 3'd7);
        end else if (nib_cnt == 3'd7) begin
          err_evt = 1'b1;
          state_n = UNALIGNED;
        end else begin
          adv = 1'b1;
        end
      end
      default: state_n = UNALIGNED;
    endcase
  end

  // Next nibble/shift-register values; sr keeps the current nibble at [31:28].
  always_comb begin
    sr_n  = sr;
    nib_n = nib_cnt;
    par_n = 4'd0;
    fs_n  = 1'b0;
    if (load) begin
      sr_n  = load_word;
      nib_n = 3'd0;
      par_n = load_word[31:28];
      fs_n  = 1'b1;
    end else if (adv) begin
      sr_n  = {sr[27:0], 4'd0};
      nib_n = nib_cnt + 3'd1;
      par_n = sr[27:24];
    end
  end

  // Framing datapath, error flag and pop counter.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      phase_q       <= 1'b0;
      sr            <= '0;
      nib_cnt       <= '0;
      cmd_par_o     <= '0;
      frame_start_o <= 1'b0;
      align_err_o   <= 1'b0;
      cmd_count_o   <= '0;
    end else begin
      phase_q       <= sysclk_phase_i;
      sr            <= sr_n;
      nib_cnt       <= nib_n;
      cmd_par_o     <= par_n;
      frame_start_o <= fs_n;
      if (err_evt)        align_err_o <= 1'b1;
      else if (err_clr_i) align_err_o <= 1'b0;
      if (pop) cmd_count_o <= cmd_count_o + 16'd1;
    end
  end

  // Occupancy for the next edge; tready is registered from it.
  always_comb begin
    occ_n = occ;
    if (push && !pop)      occ_n = occ + 1'b1;
    else if (pop && !push) occ_n = occ - 1'b1;
  end

  // FIFO pointers, occupancy and ready.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      cmd_tready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ        <= occ_n;
      cmd_tready <= (occ_n != CW'(FIFO_DEPTH));
    end
  end

  // FIFO storage.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= cmd_tdata;
  end

endmodule
